// File: rtl/add_p3_pkg.sv
// Shared FPU definitions for the add pipeline's stage-3 normalizer:
// field widths, special exponents, skid-buffer occupancy states and the entry layout.
package add_p3_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 24;

    localparam logic [EXP_W-1:0] EXP_ZERO    = 8'h00;
    localparam logic [EXP_W-1:0] EXP_MAX_FIN = 8'hFE;
    localparam logic [EXP_W-1:0] EXP_INF     = 8'hFF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [EXP_W-1:0]  lzc;
        logic [MANT_W-1:0] mant;
    } entry_t;
endpackage

// File: rtl/add_p3_lzc24.sv
// Combinational leading-zero counter over a 24-bit mantissa; returns 24 for an all-zero input.
module lzc24 (
    input  logic [23:0] i_data,
    output logic [4:0]  o_count
);
    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        o_count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (i_data[i]) o_count = 5'(23 - i);
        end
    end
endmodule

// File: rtl/add_p3.sv
// Adder stage 3: normalizes the raw mantissa sum and queues results in a 2-entry skid buffer.
// Optional round-to-nearest-even is enabled by defining ADD_P3_ROUND_EN (truncation otherwise).
module add_p3
    import add_p3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [24:0]       sum_mant_s3,
    input  logic [EXP_W-1:0]  exp_large_s3,
    input  logic              sign_s3,
    input  logic [1:0]        grs_s3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_large_out_s4,
    output logic [EXP_W-1:0]  leading_zero_ctr,
    output logic [MANT_W-1:0] left_shifted_mant,
    output logic              sign_out_s4
);
    logic [4:0] w_z;
    logic [4:0] w_shift;
    entry_t     w_norm;
    entry_t     w_entry;

    lzc24 u_lzc (
        .i_data  (sum_mant_s3[23:0]),
        .o_count (w_z)
    );

    // Denormal clamp: never shift further than the exponent can absorb.
    assign w_shift = ({3'b000, w_z} < exp_large_s3) ? w_z : exp_large_s3[4:0];

    always_comb begin
        w_norm = '0;
        if (sum_mant_s3[24]) begin
            w_norm.sign = sign_s3;
            if (exp_large_s3 == EXP_MAX_FIN) begin
                w_norm.exp = EXP_INF;
            end else begin
                w_norm.exp  = exp_large_s3 + 8'd1;
                w_norm.mant = sum_mant_s3[24:1];
            end
        end else if (sum_mant_s3[23:0] != '0) begin
            w_norm.sign = sign_s3;
            w_norm.exp  = exp_large_s3;
            w_norm.lzc  = {3'b000, w_shift};
            w_norm.mant = sum_mant_s3[23:0] << w_shift;
        end
    end

`ifdef ADD_P3_ROUND_EN
    logic          w_r;
    logic          w_st;
    logic [MANT_W:0] w_inc;

    always_comb begin
        w_entry = w_norm;
        w_r     = 1'b0;
        w_st    = 1'b0;
        if (sum_mant_s3[24] && exp_large_s3 != EXP_MAX_FIN) begin
            w_r  = sum_mant_s3[0];
            w_st = |grs_s3;
        end else if (!sum_mant_s3[24] && sum_mant_s3[23:0] != '0) begin
            if (w_z == 5'd0) begin
                w_r  = grs_s3[1];
                w_st = grs_s3[0];
            end else if (w_shift == 5'd1) begin
                w_entry.mant[0] = grs_s3[1];
            end
        end
        w_inc = {1'b0, w_entry.mant} + 25'd1;
        if (w_r && (w_st || w_entry.mant[0])) begin
            if (w_inc[MANT_W]) begin
                w_entry.mant = 24'h800000;
                w_entry.exp  = w_entry.exp + 8'd1;
            end else begin
                w_entry.mant = w_inc[MANT_W-1:0];
            end
        end
    end
`else
    logic w_unused_grs;
    assign w_unused_grs = ^grs_s3;
    assign w_entry      = w_norm;
`endif

    occ_state_t r_state;
    occ_state_t w_state_next;
    entry_t     r_head;
    entry_t     r_tail;
    logic       r_in_ready;
    logic       w_in_xfer;
    logic       w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = (r_state != ST_EMPTY) && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_in_xfer) w_state_next = ST_ONE;
            ST_ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_state_next = ST_TWO;
                else if (!w_in_xfer && w_out_xfer) w_state_next = ST_EMPTY;
            end
            ST_TWO:   if (w_out_xfer) w_state_next = ST_ONE;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    // Head always drives the outputs; the tail only fills while the head is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_TWO);
            case (r_state)
                ST_EMPTY: if (w_in_xfer) r_head <= w_entry;
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) r_head <= w_entry;
                    else if (w_in_xfer)          r_tail <= w_entry;
                end
                ST_TWO:   if (w_out_xfer) r_head <= r_tail;
                default:  ;
            endcase
        end
    end

    assign in_ready          = r_in_ready;
    assign out_valid         = (r_state != ST_EMPTY);
    assign sign_out_s4       = r_head.sign;
    assign exp_large_out_s4  = r_head.exp;
    assign leading_zero_ctr  = r_head.lzc;
    assign left_shifted_mant = r_head.mant;
endmodule

// File: tb/tb_add_p3.sv
// Randomized and directed bench for add_p3 with a queue scoreboard and an arithmetic reference model.
module tb_add_p3;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] sum_mant_s3 = '0;
    logic [7:0]  exp_large_s3 = '0;
    logic        sign_s3 = 1'b0;
    logic [1:0]  grs_s3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_large_out_s4;
    logic [7:0]  leading_zero_ctr;
    logic [23:0] left_shifted_mant;
    logic        sign_out_s4;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_out = 0;
    logic [40:0] q[$];

    always #5 clk = ~clk;

    add_p3 dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .sum_mant_s3       (sum_mant_s3),
        .exp_large_s3      (exp_large_s3),
        .sign_s3           (sign_s3),
        .grs_s3            (grs_s3),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .exp_large_out_s4  (exp_large_out_s4),
        .leading_zero_ctr  (leading_zero_ctr),
        .left_shifted_mant (left_shifted_mant),
        .sign_out_s4       (sign_out_s4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [40:0] dut_out();
        return {sign_out_s4, exp_large_out_s4, leading_zero_ctr, left_shifted_mant};
    endfunction

    // Reference result {sign, exp, lzc, mant} derived from the normalization rules.
    function automatic logic [40:0] model(input logic [24:0] s, input logic [7:0] e,
                                          input logic sg, input logic [1:0] g);
        int          z;
        int          sh;
        logic [23:0] m;
        logic [7:0]  xe;
        logic        r;
        logic        st;
        r  = 1'b0;
        st = 1'b0;
        if (s == 25'd0) return '0;
        if (s[24]) begin
            if (e == 8'd254) return {sg, 8'hFF, 8'h00, 24'h000000};
            m  = s[24:1];
            xe = e + 8'd1;
            sh = 0;
            r  = s[0];
            st = g[1] | g[0];
        end else begin
            z = 0;
            while (s[23 - z] == 1'b0) z++;
            sh = (z < int'(e)) ? z : int'(e);
            m  = s[23:0] << sh;
            xe = e;
            if (z == 0) begin
                r  = g[1];
                st = g[0];
            end
`ifdef ADD_P3_ROUND_EN
            else if (sh == 1) m[0] = g[1];
`endif
        end
`ifdef ADD_P3_ROUND_EN
        if (r && (st || m[0])) begin
            if (m == 24'hFFFFFF) begin
                m  = 24'h800000;
                xe = xe + 8'd1;
            end else begin
                m = m + 24'd1;
            end
        end
`else
        if (r && st && 1'b0) m = '0;
`endif
        return {sg, xe, 8'(sh), m};
    endfunction

    // One cycle: called just after a negedge, drives inputs, scores transfers, returns at next negedge.
    task automatic step(input logic iv, input logic [24:0] s, input logic [7:0] e,
                        input logic sg, input logic [1:0] g, input logic ordy);
        logic [40:0] want;
        in_valid     = iv;
        sum_mant_s3  = s;
        exp_large_s3 = e;
        sign_s3      = sg;
        grs_s3       = g;
        out_ready    = ordy;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                want = q.pop_front();
                n_out++;
                $display("out %0d: sign=%0d exp=0x%02h lzc=%0d mant=0x%06h", n_out,
                         sign_out_s4, exp_large_out_s4, leading_zero_ctr, left_shifted_mant);
                chk("scoreboard", dut_out(), want);
            end
        end
        if (in_valid && in_ready) q.push_back(model(s, e, sg, g));
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q.size() != 0 || out_valid) && budget < 20) begin
            step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1);
            budget++;
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        logic [24:0] rs;
        logic [7:0]  re;
        logic [40:0] first;

        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data", dut_out(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_edge", in_ready, 1);

        step(1'b1, 25'h1800000, 8'h80, 1'b0, 2'b00, 1'b0);
        chk("carry_valid", out_valid, 1);
        chk("carry_exp", exp_large_out_s4, 8'h81);
        chk("carry_lzc", leading_zero_ctr, 8'd0);
        chk("carry_mant", left_shifted_mant, 24'hC00000);
        drain();

        step(1'b1, 25'h0000F00, 8'h90, 1'b1, 2'b00, 1'b0);
        chk("norm_lzc", leading_zero_ctr, 8'd12);
        chk("norm_mant", left_shifted_mant, 24'hF00000);
        chk("norm_exp", exp_large_out_s4, 8'h90);
        chk("norm_sign", sign_out_s4, 1);
        drain();

        step(1'b1, 25'h0000001, 8'd5, 1'b0, 2'b00, 1'b0);
        chk("clamp_lzc", leading_zero_ctr, 8'd5);
        chk("clamp_mant", left_shifted_mant, 24'h000020);
        chk("clamp_exp", exp_large_out_s4, 8'd5);
        drain();

        step(1'b1, 25'h0000000, 8'h44, 1'b1, 2'b00, 1'b0);
        chk("zero_valid", out_valid, 1);
        chk("zero_all", dut_out(), 0);
        drain();

        step(1'b1, 25'h1ABCDEF, 8'd254, 1'b1, 2'b00, 1'b0);
        chk("inf_all", dut_out(), {1'b1, 8'hFF, 8'h00, 24'h000000});
        drain();

`ifdef ADD_P3_ROUND_EN
        step(1'b1, 25'h0FFFFFF, 8'h7F, 1'b0, 2'b11, 1'b0);
        chk("round_mant", left_shifted_mant, 24'h800000);
        chk("round_exp", exp_large_out_s4, 8'h80);
        drain();
`endif

        // Back-pressure: two accepted, third held off, then released in order.
        step(1'b1, 25'h0123456, 8'h40, 1'b0, 2'b00, 1'b0);
        first = dut_out();
        step(1'b1, 25'h1777777, 8'h20, 1'b1, 2'b00, 1'b0);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        step(1'b1, 25'h0000ABC, 8'h60, 1'b0, 2'b00, 1'b0);
        chk("full_still_blocked", in_ready, 0);
        chk("full_head_stable", dut_out(), first);
        chk("full_queue_depth", q.size(), 2);
        drain();

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rs = 25'($urandom);
                1:       rs = {1'b0, 24'($urandom) >> $urandom_range(0, 23)};
                2:       rs = ($urandom_range(0, 3) == 0) ? 25'd0 : {1'b0, 24'd1 << $urandom_range(0, 23)};
                default: rs = {1'b1, 24'($urandom)};
            endcase
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 24)) : 8'($urandom_range(0, 254));
            step(1'($urandom_range(0, 1)), rs, re, 1'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset while both entries are occupied.
        step(1'b1, 25'h0400000, 8'h10, 1'b0, 2'b00, 1'b0);
        step(1'b1, 25'h0200000, 8'h11, 1'b1, 2'b00, 1'b0);
        chk("two_in_ready", in_ready, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_data", dut_out(), 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("release_in_ready_pre", in_ready, 0);
        @(negedge clk);
        chk("release_in_ready_post", in_ready, 1);
        chk("release_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/add_p3.md
ADD_P3 -- requirements
Module: add_p3

Interface
REQ-001 SHALL have clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have rst, input, 1 bit, reset: asynchronous, active-high.
REQ-003 SHALL have in_valid, input, 1 bit, upstream (alignment/add stage) result valid.
REQ-004 SHALL have in_ready, output, 1 bit, stage can accept; transfer on in_valid && in_ready at posedge.
REQ-005 SHALL have sum_mant_s3, input, 25 bits, raw mantissa sum; bit 24 = carry-out.
REQ-006 SHALL have exp_large_s3, input, 8 bits, larger operand exponent.
REQ-007 SHALL have sign_s3, input, 1 bit, result sign.
REQ-008 SHALL have grs_s3, input, 2 bits, {guard, sticky} from alignment; used only under ADD_P3_ROUND_EN.
REQ-009 SHALL have out_valid, output, 1 bit, output entry valid.
REQ-010 SHALL have out_ready, input, 1 bit, normalize/pack stage accepts; transfer on out_valid && out_ready.
REQ-011 SHALL have exp_large_out_s4, output, 8 bits, exponent before leading-zero subtraction.
REQ-012 SHALL have leading_zero_ctr, output, 8 bits, left-shift amount applied; the pack stage subtracts it.
REQ-013 SHALL have left_shifted_mant, output, 24 bits, normalized mantissa, bit 23 = hidden bit.
REQ-014 SHALL have sign_out_s4, output, 1 bit, result sign.

Function
REQ-015 SHALL compute normalization combinationally from inputs and capture the result on input transfer.
- Carry (sum[24]=1): mant=sum[24:1], exp=exp_large+1, lzc=0.
- Carry with exp_large=254: exp=255, mant=0, lzc=0 (infinity).
REQ-016 SHALL handle non-zero, no-carry inputs as follows:
- z = leading zeros of sum[23:0] (0..23).
- s = (z < exp_large) ? z : exp_large (denormal clamp).
- mant = sum[23:0] << s; lzc = s; exp = exp_large.
REQ-017 SHALL output all-zero sum as mant=0, exp=0, lzc=0, sign=0.
REQ-018 SHALL fill bits shifted into the LSB with zeros when ADD_P3_ROUND_EN is undefined.
REQ-019 SHALL implement a 2-entry output skid buffer.
- Occupancy FSM: EMPTY, ONE, TWO.
- Input transfer only: EMPTY->ONE, ONE->TWO.
- Output transfer only: TWO->ONE, ONE->EMPTY.
- Simultaneous input and output transfer: state unchanged.
REQ-020 SHALL drive in_ready as a registered signal, equal to 1 when state != TWO.
REQ-021 SHALL have latency of 1 cycle from input transfer to out_valid when EMPTY.
REQ-022 SHALL preserve FIFO order and hold outputs stable while out_valid && !out_ready.
REQ-023 SHALL never drop or duplicate an entry.
REQ-024 SHALL present the head entry on the outputs; out_valid = (state != EMPTY).

Reset
REQ-025 SHALL on rst, immediately and regardless of clk:
- go to EMPTY; out_valid=0; in_ready=0.
- all data outputs and buffer registers = 0.
REQ-026 SHALL discard in-flight entries when rst asserts mid-operation.
REQ-027 SHALL raise in_ready on the first clk edge after rst deasserts.

Configuration
REQ-028 SHALL, when ADD_P3_ROUND_EN is defined, apply round-to-nearest-even before capture:
- Carry path: r=sum[0], st=g|s.
- z=0: r=g, st=s.
- z=1: shift g into LSB, no rounding.
- z>=2: no rounding.
- Increment mant when r && (st || mant[0]).
- If the increment overflows 24 bits: mant=0x800000, exp+1.
REQ-029 SHALL, when ADD_P3_ROUND_EN is undefined, truncate, ignore grs_s3, and synthesize no rounding logic.

Structure
REQ-030 SHALL take widths (EXP_W=8, MANT_W=24), the state enum and the denormal/infinity exponent constants from the shared FPU package.
REQ-031 SHALL place the leading-zero count in one sub-module, lzc24 (24-bit in, 5-bit count, combinational).

Verification
REQ-032 SHALL cover: sum=0x1800000, exp=0x80 -> exp_out=0x81, lzc=0, mant=0xC00000.
REQ-033 SHALL cover: sum=0x0000F00, exp=0x90 -> lzc=12, mant=0xF00000, exp_out=0x90.
REQ-034 SHALL cover: sum=0x0000001, exp=5 -> lzc=5, mant=0x000020; and sum=0, sign=1 -> all zero, sign 0.
REQ-035 SHALL cover: out_ready=0, three in_valid cycles -> two accepted, in_ready=0 on third; release -> entries emerge in order, none lost.
REQ-036 SHALL cover with ADD_P3_ROUND_EN: sum=0x0FFFFFF, exp=0x7F, grs=2'b11 -> mant=0x800000, exp_out=0x80.
REQ-037 SHALL cover: rst pulse while in state TWO -> out_valid=0 immediately, in_ready=1 one edge after release.
